serial_compare_ctrl: RTL and testbench

Multi-cycle sequencer that compares two WIDTH-bit operands using one shared 4-bit magnitude-compare slice, one nibble per clock, MSB nibble first. Operands are captured on a start handshake. The block walks the nibbles and returns a one-hot {gt,lt,eq} result with a one-cycle done pulse. It sits in front of wide-operand compare users (sorters, threshold checks) that cannot afford a full-width comparator.

---
 rtl/cmp_pkg.sv | 17 +
 rtl/nibble_cmp.sv | 19 +
 rtl/serial_compare_ctrl.sv | 122 ++++++++++++
 tb/tb_serial_compare_ctrl.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/cmp_pkg.sv
// Shared encodings for the serial nibble comparator: result codes, slice width
// and sequencer states.
package cmp_pkg;

  localparam logic [2:0] CMP_GT = 3'b100;
  localparam logic [2:0] CMP_LT = 3'b010;
  localparam logic [2:0] CMP_EQ = 3'b001;

  localparam int NIB_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/nibble_cmp.sv
// Combinational 4-bit magnitude compare slice returning one-hot {gt,lt,eq}.
module nibble_cmp
  import cmp_pkg::*;
(
  input  logic [NIB_W-1:0] iA,
  input  logic [NIB_W-1:0] iB,
  output logic [2:0]       oRes
);

  always_comb begin
    oRes = CMP_EQ;
    if (iA > iB) begin
      oRes = CMP_GT;
    end else if (iA < iB) begin
      oRes = CMP_LT;
    end
  end

endmodule

// File: rtl/serial_compare_ctrl.sv
// Wide-operand comparator that walks one nibble per clock, MSB first, through a
// single shared slice. Build option: CMP_EARLY_EXIT_EN stops at the first difference.
module serial_compare_ctrl
  import cmp_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             iClk,
  input  logic             iRst,
  input  logic             iStart,
  input  logic [WIDTH-1:0] iData_a,
  input  logic [WIDTH-1:0] iData_b,
  input  logic [2:0]       iData,
  output logic             oBusy,
  output logic             oDone,
  output logic [2:0]       oData
);

  localparam int NIB   = WIDTH / NIB_W;
  localparam int IDX_W = (NIB > 1) ? $clog2(NIB) : 1;

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic [WIDTH-1:0]   b_q, b_d;
  logic [2:0]         casc_q, casc_d;
  logic [2:0]         acc_q, acc_d;
  logic [2:0]         data_q, data_d;
  logic               done_q, done_d;

  logic [WIDTH-1:0]   a_sh, b_sh;
  logic [NIB_W-1:0]   a_nib, b_nib;
  logic [2:0]         slice_res;
  logic               leave_run;

  // The single slice sees whichever nibble idx currently points at.
  assign a_sh  = a_q >> (NIB_W * idx_q);
  assign b_sh  = b_q >> (NIB_W * idx_q);
  assign a_nib = a_sh[NIB_W-1:0];
  assign b_nib = b_sh[NIB_W-1:0];

  nibble_cmp u_slice (
    .iA   (a_nib),
    .iB   (b_nib),
    .oRes (slice_res)
  );

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    a_d       = a_q;
    b_d       = b_q;
    casc_d    = casc_q;
    acc_d     = acc_q;
    data_d    = data_q;
    leave_run = 1'b0;
    done_d    = (state_q == ST_DONE);

    case (state_q)
      ST_IDLE: begin
        if (iStart) begin
          a_d     = iData_a;
          b_d     = iData_b;
          casc_d  = iData;
          idx_d   = IDX_W'(NIB - 1);
          acc_d   = CMP_EQ;
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        // First differing nibble wins; later nibbles cannot overturn it.
        if (acc_q == CMP_EQ) begin
          acc_d = slice_res;
        end
        idx_d     = idx_q - IDX_W'(1);
        leave_run = (idx_q == '0);
`ifdef CMP_EARLY_EXIT_EN
        if (acc_d != CMP_EQ) begin
          leave_run = 1'b1;
        end
`endif
        if (leave_run) begin
          state_d = ST_DONE;
          data_d  = ((acc_d == CMP_GT) || (acc_d == CMP_LT)) ? acc_d : casc_q;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      casc_q  <= '0;
      acc_q   <= '0;
      data_q  <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      a_q     <= a_d;
      b_q     <= b_d;
      casc_q  <= casc_d;
      acc_q   <= acc_d;
      data_q  <= data_d;
      done_q  <= done_d;
    end
  end

  assign oBusy = (state_q != ST_IDLE);
  assign oDone = done_q;
  assign oData = data_q;

endmodule

// File: tb/tb_serial_compare_ctrl.sv
// Directed bench for serial_compare_ctrl at WIDTH=16; latency expectations
// follow the CMP_EARLY_EXIT_EN build option.
module tb_serial_compare_ctrl;

  logic        iClk = 1'b0;
  logic        iRst = 1'b1;
  logic        iStart = 1'b0;
  logic [15:0] iData_a = '0;
  logic [15:0] iData_b = '0;
  logic [2:0]  iData = '0;
  logic        oBusy;
  logic        oDone;
  logic [2:0]  oData;

  int total = 0;
  int bad   = 0;

  serial_compare_ctrl #(.WIDTH(16)) dut (
    .iClk    (iClk),
    .iRst    (iRst),
    .iStart  (iStart),
    .iData_a (iData_a),
    .iData_b (iData_b),
    .iData   (iData),
    .oBusy   (oBusy),
    .oDone   (oDone),
    .oData   (oData)
  );

  always #5 iClk = ~iClk;

  // Launches one compare and measures it; edge 0 is the edge that samples iStart.
  task automatic run_cmp(input logic [15:0] a, input logic [15:0] b, input logic [2:0] c,
                         output int lat, output int pulses, output logic busy0);
    lat = -1;
    pulses = 0;
    @(negedge iClk);
    iData_a = a;
    iData_b = b;
    iData   = c;
    iStart  = 1'b1;
    @(posedge iClk);
    #1;
    busy0  = oBusy;
    iStart = 1'b0;
    for (int n = 1; n <= 12; n++) begin
      @(posedge iClk);
      #1;
      if (oDone === 1'b1) begin
        if (lat < 0) lat = n;
        pulses++;
      end
    end
  endtask

  task automatic test_reset;
    iRst = 1'b1;
    repeat (2) @(posedge iClk);
    #1;
    total++; if (oBusy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", oBusy); end
    total++; if (oDone !== 1'b0) begin bad++; $display("FAIL reset_done got=%b exp=0", oDone); end
    total++; if (oData !== 3'b000) begin bad++; $display("FAIL reset_data got=%b exp=000", oData); end
    @(negedge iClk);
    iRst = 1'b0;
  endtask

  task automatic test_full_scan;
    int lat, pulses; logic busy0;
    run_cmp(16'h1234, 16'h1235, 3'b001, lat, pulses, busy0);
    total++; if (busy0 !== 1'b1) begin bad++; $display("FAIL full_busy got=%b exp=1", busy0); end
    total++; if (lat != 5) begin bad++; $display("FAIL full_latency got=%0d exp=5", lat); end
    total++; if (pulses != 1) begin bad++; $display("FAIL full_pulses got=%0d exp=1", pulses); end
    total++; if (oData !== 3'b010) begin bad++; $display("FAIL full_data got=%b exp=010", oData); end
  endtask

  task automatic test_early_exit;
    int lat, pulses, exp_lat; logic busy0;
`ifdef CMP_EARLY_EXIT_EN
    exp_lat = 2;
`else
    exp_lat = 5;
`endif
    run_cmp(16'hF000, 16'h0FFF, 3'b001, lat, pulses, busy0);
    total++; if (lat != exp_lat) begin bad++; $display("FAIL early_latency got=%0d exp=%0d", lat, exp_lat); end
    total++; if (pulses != 1) begin bad++; $display("FAIL early_pulses got=%0d exp=1", pulses); end
    total++; if (oData !== 3'b100) begin bad++; $display("FAIL early_data got=%b exp=100", oData); end
  endtask

  task automatic test_cascade;
    int lat, pulses; logic busy0;
    logic [2:0] casc [3];
    casc[0] = 3'b100; casc[1] = 3'b010; casc[2] = 3'b000;
    for (int i = 0; i < 3; i++) begin
      run_cmp(16'hABCD, 16'hABCD, casc[i], lat, pulses, busy0);
      total++; if (oData !== casc[i]) begin bad++; $display("FAIL cascade_data[%0d] got=%b exp=%b", i, oData, casc[i]); end
      total++; if (lat != 5) begin bad++; $display("FAIL cascade_latency[%0d] got=%0d exp=5", i, lat); end
    end
    run_cmp(16'h5555, 16'h5555, 3'b111, lat, pulses, busy0);
    total++; if (oData !== 3'b111) begin bad++; $display("FAIL cascade_data_111 got=%b exp=111", oData); end
  endtask

  task automatic test_start_ignored;
    int pulses = 0;
    @(negedge iClk);
    iData_a = 16'h0001; iData_b = 16'h0002; iData = 3'b001; iStart = 1'b1;
    @(posedge iClk);
    #1;
    iStart = 1'b0;
    for (int n = 1; n <= 12; n++) begin
      if (n == 2) begin
        iData_a = 16'hFFFF; iData_b = 16'h0000; iStart = 1'b1;
      end else begin
        iStart = 1'b0;
      end
      @(posedge iClk);
      #1;
      if (oDone === 1'b1) pulses++;
    end
    iStart = 1'b0;
    total++; if (pulses != 1) begin bad++; $display("FAIL ignore_pulses got=%0d exp=1", pulses); end
    total++; if (oData !== 3'b010) begin bad++; $display("FAIL ignore_data got=%b exp=010", oData); end
    total++; if (oBusy !== 1'b0) begin bad++; $display("FAIL ignore_idle_busy got=%b exp=0", oBusy); end
  endtask

  task automatic test_reset_abort;
    int lat, pulses, exp_lat; logic busy0;
`ifdef CMP_EARLY_EXIT_EN
    exp_lat = 2;
`else
    exp_lat = 5;
`endif
    @(negedge iClk);
    iData_a = 16'h1234; iData_b = 16'h1235; iData = 3'b001; iStart = 1'b1;
    @(posedge iClk);
    #1;
    iStart = 1'b0;
    repeat (2) @(posedge iClk);
    #2;
    total++; if (oBusy !== 1'b1) begin bad++; $display("FAIL abort_pre_busy got=%b exp=1", oBusy); end
    iRst = 1'b1;
    #1;
    total++; if (oBusy !== 1'b0) begin bad++; $display("FAIL abort_busy got=%b exp=0", oBusy); end
    total++; if (oDone !== 1'b0) begin bad++; $display("FAIL abort_done got=%b exp=0", oDone); end
    total++; if (oData !== 3'b000) begin bad++; $display("FAIL abort_data got=%b exp=000", oData); end
    @(negedge iClk);
    iRst = 1'b0;
    run_cmp(16'h8000, 16'h7FFF, 3'b001, lat, pulses, busy0);
    total++; if (oData !== 3'b100) begin bad++; $display("FAIL abort_after_data got=%b exp=100", oData); end
    total++; if (lat != exp_lat) begin bad++; $display("FAIL abort_after_latency got=%0d exp=%0d", lat, exp_lat); end
    total++; if (pulses != 1) begin bad++; $display("FAIL abort_after_pulses got=%0d exp=1", pulses); end
  endtask

  task automatic test_back_to_back;
    logic exp_done;
    @(negedge iClk);
    iData_a = 16'h1234; iData_b = 16'h1235; iData = 3'b001; iStart = 1'b1;
    @(posedge iClk);
    for (int n = 1; n <= 17; n++) begin
      @(posedge iClk);
      #1;
      exp_done = (n == 5) || (n == 11) || (n == 17);
      total++; if (oDone !== exp_done) begin bad++; $display("FAIL b2b_done edge=%0d got=%b exp=%b", n, oDone, exp_done); end
      total++; if (oBusy !== !exp_done) begin bad++; $display("FAIL b2b_busy edge=%0d got=%b exp=%b", n, oBusy, !exp_done); end
    end
    iStart = 1'b0;
    total++; if (oData !== 3'b010) begin bad++; $display("FAIL b2b_data got=%b exp=010", oData); end
    repeat (8) @(posedge iClk);
    #1;
    total++; if (oBusy !== 1'b0) begin bad++; $display("FAIL b2b_final_busy got=%b exp=0", oBusy); end
  endtask

  initial begin
    test_reset();
    test_full_scan();
    test_early_exit();
    test_cascade();
    test_start_ignored();
    test_reset_abort();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
